// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg
// Shared definitions for the batch accumulator: sequencer state encoding,
// IEEE-754 single-precision field positions and the all-zero encoding.
// No ports (package).
package fp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_LSB  = 23;
  localparam int SIGN_BIT = 31;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_add_core.sv
// fp_add_core
// Combinational single-precision adder with truncation and no special-value
// handling. An operand whose exponent field is zero counts as zero and the
// other operand passes straight through.
// Ports:
//   a    in  32  first operand; wins as base on equal exponents
//   b    in  32  second operand
//   sum  out 32  a + b
module fp_add_core
  import fp_sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;

  assign sign_a = a[SIGN_BIT];
  assign sign_b = b[SIGN_BIT];
  assign exp_a  = a[EXP_LSB +: EXP_W];
  assign exp_b  = b[EXP_LSB +: EXP_W];
  // hidden 1 restored
  assign man_a  = {1'b1, a[MAN_W-1:0]};
  assign man_b  = {1'b1, b[MAN_W-1:0]};

  logic             base_sign;
  logic [EXP_W-1:0] base_exp, small_exp, shift, res_exp;
  logic [MAN_W:0]   base_man, small_man, small_aligned, sub_res, res_man;
  logic [MAN_W+1:0] add_res;

  always_comb begin
    if (exp_b > exp_a) begin
      base_sign = sign_b;
      base_exp  = exp_b;
      base_man  = man_b;
      small_exp = exp_a;
      small_man = man_a;
    end else begin
      base_sign = sign_a;
      base_exp  = exp_a;
      base_man  = man_a;
      small_exp = exp_b;
      small_man = man_b;
    end

    shift         = base_exp - small_exp;
    small_aligned = small_man >> shift;
    add_res       = {1'b0, base_man} + {1'b0, small_aligned};
    sub_res       = base_man - small_aligned;

    res_exp = base_exp;
    if (sign_a == sign_b) begin
      if (add_res[MAN_W+1]) begin
        res_man = add_res[MAN_W+1:1];
        res_exp = base_exp + 8'd1;
      end else begin
        res_man = add_res[MAN_W:0];
      end
    end else begin
      res_man = sub_res;
      // Cancellation can leave the leading one anywhere; walk it back up to
      // the hidden-bit position. A zero difference never normalizes.
      for (int i = 0; i < MAN_W + 1; i++) begin
        if (!res_man[MAN_W] && (res_man != '0)) begin
          res_man = res_man << 1;
          res_exp = res_exp - 8'd1;
        end
      end
    end

    if (exp_a == '0)
      sum = b;
    else if (exp_b == '0)
      sum = a;
    else if (res_man == '0)
      sum = FP_ZERO;
    else
      sum = {base_sign, res_exp, res_man[MAN_W-1:0]};
  end

endmodule

// File: rtl/fp_accum_sequencer.sv
// fp_accum_sequencer
// Folds a batch of single-precision samples into one sum using a single
// time-shared adder, one sample per cycle, and holds the sum on a
// valid/ready output until taken.
// Ports:
//   clk        in   1      clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin a batch (only looked at in IDLE)
//   count      in   CNT_W  batch length, taken with start
//   in_valid   in   1      sample valid
//   in_data    in   XLEN   sample
//   in_ready   out  1      sample accepted this cycle
//   out_valid  out  1      sum available
//   out_data   out  XLEN   accumulated sum
//   out_ready  in   1      consumer takes the sum
//   busy       out  1      any state other than IDLE
//   err        out  1      one-cycle pulse on a rejected batch length
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start with a legal count
// ST_FIRST | first sample loads acc directly, no add
// ST_ACCUM | each sample is added into acc
// ST_DONE  | sum held on out_data until out_ready
module fp_accum_sequencer
  import fp_sched_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_MAX = 16,
  parameter int CNT_W = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  add_sum;

  fp_add_core u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum)
  );

  // Handshake outputs come from the state register only, so the upstream
  // valid and downstream ready never feed back combinationally.
  assign in_ready  = (state == ST_FIRST) || (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      acc       <= FP_ZERO;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if ((count == '0) || (count > N_MAX_C)) begin
              err <= 1'b1;
            end else begin
              remaining <= count;
              state     <= ST_FIRST;
            end
          end
        end
        ST_FIRST: begin
          if (in_valid) begin
            acc       <= in_data;
            remaining <= remaining - ONE_C;
            state     <= (remaining == ONE_C) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc       <= add_sum;
            remaining <= remaining - ONE_C;
            if (remaining == ONE_C)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
